// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation driver and its flip-flop bank.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXCITE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    // JK input pairs written as {J,K}
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    // Number of ones in a word of up to 16 bits
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops, cleared asynchronously to 0. No control logic.
module jk_bank
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Each bit follows the JK characteristic: hold, reset, set or toggle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    HOLD:    r_q[i] <= r_q[i];
                    RESET:   r_q[i] <= 1'b0;
                    SET:     r_q[i] <= 1'b1;
                    TOGGLE:  r_q[i] <= ~r_q[i];
                endcase
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_excite_driver.sv
// Accepts target states, derives one cycle of J/K excitation for the bank,
// then confirms the bank landed on the target and reports the toggle count.
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             use_toggle,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic [CW-1:0]    tog_cnt,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_tgt;
    logic             r_mode;
    logic [CW-1:0]    r_tog;
    logic             r_err;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    jk_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .clr (clr),
        .j   (w_j),
        .k   (w_k),
        .q   (w_q)
    );

    assign w_diff = r_tgt ^ w_q;

    // Excitation is only driven in EXCITE; unchanged bits fall out as J=K=0
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == EXCITE) begin
            if (r_mode) begin
                w_j = w_diff;
                w_k = w_diff;
            end else begin
                w_j = r_tgt & ~w_q;
                w_k = ~r_tgt & w_q;
            end
        end
    end

    // Transaction sequencing: capture target, excite once, check result
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_mode  <= 1'b0;
            r_tog   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tgt_valid) begin
                        r_tgt   <= tgt_data;
                        r_mode  <= use_toggle;
                        r_state <= EXCITE;
                    end
                end
                EXCITE: begin
                    r_tog   <= CW'(popcount(16'(w_diff)));
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_q != r_tgt) begin
                        r_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready is held low while clr is asserted even though the state reads IDLE
    assign tgt_ready = (r_state == IDLE) && !clr;
    assign done      = (r_state == CHECK);
    assign j         = w_j;
    assign k         = w_k;
    assign q         = w_q;
    assign tog_cnt   = r_tog;
    assign err       = r_err;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Randomised scoreboard bench for jk_excite_driver with a per-bit JK reference model.
module tb_jk_excite_driver;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             tgt_valid = 1'b0;
    logic             use_toggle = 1'b0;
    logic [WIDTH-1:0] tgt_data = '0;
    logic             tgt_ready;
    logic [WIDTH-1:0] j, k, q;
    logic             done;
    logic [CW-1:0]    tog_cnt;
    logic             err;

    jk_excite_driver #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .clr        (clr),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_data   (tgt_data),
        .use_toggle (use_toggle),
        .j          (j),
        .k          (k),
        .q          (q),
        .done       (done),
        .tog_cnt    (tog_cnt),
        .err        (err)
    );

    typedef struct {
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        logic [WIDTH-1:0] q_seen;
        int               tog;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    logic [WIDTH-1:0] m_q   = '0;
    logic             m_err = 1'b0;
    logic exc_next = 1'b0;
    logic err_pend = 1'b0;
    logic err_exp  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: each bit decides its own JK pair from (current, target, mode)
    function automatic exp_t model(input logic [WIDTH-1:0] tgt, input logic mode,
                                   input logic fault, input logic [WIDTH-1:0] forced);
        exp_t e;
        e.ej = '0; e.ek = '0; e.tog = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m_q[i] != tgt[i]) begin
                e.tog++;
                if (mode) begin
                    e.ej[i] = 1'b1; e.ek[i] = 1'b1;
                end else if (tgt[i]) begin
                    e.ej[i] = 1'b1;
                end else begin
                    e.ek[i] = 1'b1;
                end
            end
        end
        e.q_seen = fault ? forced : tgt;
        e.err    = m_err || (e.q_seen != tgt);
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] tgt, input logic mode, input logic hold,
                        input logic fault);
        exp_t e;
        int   w;
        @(posedge clk); #1;
        tgt_data   = tgt;
        use_toggle = mode;
        tgt_valid  = 1'b1;
        @(negedge clk);
        w = 0;
        while (!tgt_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!tgt_ready) begin
            check("accept_timeout", 0, 1);
            tgt_valid = 1'b0;
            return;
        end
        e = model(tgt, mode, fault, m_q);
        sb.push_back(e);
        m_q   = tgt;
        m_err = e.err;
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (!hold) begin
            tgt_valid  = 1'b0;
            tgt_data   = WIDTH'($urandom);
            use_toggle = 1'($urandom);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || err_pend) && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", int'(sb.size() == 0 && !err_pend), 1);
    endtask

    // Monitor: check excitation in EXCITE, results on done, sticky err afterwards
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            exc_next = 1'b0;
            err_pend = 1'b0;
            check("done_in_clr", int'(done), 0);
            check("ready_in_clr", int'(tgt_ready), 0);
        end else begin
            if (err_pend) begin
                check("err", int'(err), int'(err_exp));
                err_pend = 1'b0;
            end
            if (exc_next) begin
                exc_next = 1'b0;
                if (sb.size() == 0) begin
                    check("excite_without_expect", 1, 0);
                end else begin
                    check("j_excite", int'(j), int'(sb[0].ej));
                    check("k_excite", int'(k), int'(sb[0].ek));
                    check("ready_excite", int'(tgt_ready), 0);
                end
            end else if (!done) begin
                check("j_zero", int'(j), 0);
                check("k_zero", int'(k), 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("q_check", int'(q), int'(e.q_seen));
                    check("tog_cnt", int'(tog_cnt), e.tog);
                    check("ready_check", int'(tgt_ready), 0);
                    check("jk_check", int'({j, k}), 0);
                    err_exp  = e.err;
                    err_pend = 1'b1;
                end
            end
            if (tgt_valid && tgt_ready) exc_next = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        logic [WIDTH-1:0] r;
        #1 clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_j", int'(j), 0);
        check("rst_k", int'(k), 0);
        check("rst_ready", int'(tgt_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_tog", int'(tog_cnt), 0);

        send(4'b1010, 1'b0, 1'b0, 1'b0); wait_drain();
        send(4'b0110, 1'b0, 1'b0, 1'b0); wait_drain();
        send(4'b1001, 1'b1, 1'b0, 1'b0); wait_drain();
        send(4'b1001, 1'b0, 1'b0, 1'b0); wait_drain();

        send(4'b0001, 1'b0, 1'b1, 1'b0);
        c1 = acc_cyc;
        send(4'b0011, 1'b0, 1'b0, 1'b0);
        check("b2b_spacing", acc_cyc - c1, 3);
        wait_drain();

        for (int i = 0; i < 24; i++) begin
            r = WIDTH'($urandom);
            send(r, 1'($urandom), (i < 23) ? 1'($urandom) : 1'b0, 1'b0);
        end
        wait_drain();

        send(4'b1111, 1'b0, 1'b0, 1'b0);
        #1 clr = 1'b1;
        sb.delete();
        m_q = '0;
        m_err = 1'b0;
        #1;
        check("clr_async_q", int'(q), 0);
        check("clr_async_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("post_clr_ready", int'(tgt_ready), 1);
        check("post_clr_q", int'(q), 0);

        send(4'b0000, 1'b0, 1'b0, 1'b0); wait_drain();
        force u_dut.w_q = 4'b0000;
        send(4'b0001, 1'b0, 1'b0, 1'b1); wait_drain();
        release u_dut.w_q;
        for (int i = 0; i < 4; i++) begin
            send(WIDTH'($urandom), 1'($urandom), 1'b0, 1'b0);
            wait_drain();
        end
        @(negedge clk);
        check("err_sticky", int'(err), 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_q = '0; m_err = 1'b0;
        @(negedge clk);
        check("err_cleared", int'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
